// File: rtl/alu_exec_unit_if.sv
// Request/response channel bundle for alu_exec_unit.
// The master side issues operands and opcodes and consumes results. The slave side is the execution unit.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_ex;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_ex, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_ex, rsp_ovf
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage handshaked ALU (AND/OR/ADD/SUB/SLT) with full backpressure.
// The module also counts completed responses.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_exec_unit_if.slave   bus,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_z_q;
  logic             s2_ex_q;
  logic             s2_ovf_q;
  logic [CNT_W-1:0] op_count_q;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] z_d;
  logic             ex_d;
  logic             ovf_d;

  assign s2_free  = !s2_valid_q || bus.rsp_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  // Held low during reset so nothing is accepted into a pipeline that is being cleared.
  assign bus.req_ready = !reset && (!s1_valid_q || s2_free);
  assign accept   = bus.req_valid && bus.req_ready;
  assign rsp_fire = s2_valid_q && bus.rsp_ready;

  always_comb begin
    sum   = s1_a_q + s1_b_q;
    diff  = s1_a_q - s1_b_q;
    z_d   = '0;
    ovf_d = 1'b0;
    case (s1_op_q)
      3'b000, 3'b100: z_d = s1_a_q & s1_b_q;
      3'b001, 3'b101: z_d = s1_a_q | s1_b_q;
      3'b010: begin
        z_d   = sum;
        ovf_d = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b110: begin
        z_d   = diff;
        ovf_d = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b111: z_d[0] = $signed(s1_a_q) < $signed(s1_b_q);
      default: z_d = '0;
    endcase
    ex_d = (z_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_ex_q    <= 1'b0;
      s2_ovf_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      // Operands load only on a real handshake, so idle-bus garbage never enters S1.
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= bus.req_a;
        s1_b_q     <= bus.req_b;
        s1_op_q    <= bus.req_op;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_z_q     <= z_d;
        s2_ex_q    <= ex_d;
        s2_ovf_q   <= ovf_d;
      end else if (rsp_fire) begin
        s2_valid_q <= 1'b0;
      end
      if (rsp_fire) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_z     = s2_z_q;
  assign bus.rsp_ex    = s2_ex_q;
  assign bus.rsp_ovf   = s2_ovf_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random bench for alu_exec_unit.
// An arithmetic reference model feeds a per-cycle scoreboard that checks the DUT against it.
module tb_alu_exec_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [31:0] z;
    logic        ex;
    logic        ovf;
    int unsigned acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] op_count;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned naccept = 0;
  exp_t        q[$];
  logic [15:0] mcnt = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_z;
  logic        prev_ex;
  logic        prev_ovf;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference ALU: plain signed arithmetic, overflow judged by range of the exact result.
  function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.z = '0;
    e.ovf = 1'b0;
    e.acc = 0;
    case (op)
      3'd0, 3'd4: e.z = a & b;
      3'd1, 3'd5: e.z = a | b;
      3'd2, 3'd6: begin
        r = (op == 3'd2) ? sa + sb : sa - sb;
        e.z = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd7: e.z = (sa < sb) ? 32'd1 : 32'd0;
      default: e.z = '0;
    endcase
    e.ex = (e.z == 32'd0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: one check pass per cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_valid;
    if (reset) begin
      chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
      q.delete();
      mcnt = '0;
      prev_hold = 1'b0;
    end else begin
      chk("req_ready", 64'(bus.req_ready), 64'(q.size() < 2 || bus.rsp_ready));
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
      if (bus.rsp_valid && exp_valid) begin
        chk("rsp_z", 64'(bus.rsp_z), 64'(q[0].z));
        chk("rsp_ex", 64'(bus.rsp_ex), 64'(q[0].ex));
        chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(q[0].ovf));
      end
      if (prev_hold) begin
        chk("hold_z", 64'(bus.rsp_z), 64'(prev_z));
        chk("hold_flags", 64'({bus.rsp_ex, bus.rsp_ovf}), 64'({prev_ex, prev_ovf}));
      end
      chk("op_count", 64'(op_count), 64'(mcnt));
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_z = bus.rsp_z;
      prev_ex = bus.rsp_ex;
      prev_ovf = bus.rsp_ovf;
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (bus.req_valid && bus.req_ready) begin
        e = ref_alu(bus.req_a, bus.req_b, bus.req_op);
        e.acc = cyc;
        q.push_back(e);
        naccept++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input logic [31:0] ez, input logic eex, input logic eovf);
    exp_t e;
    e = ref_alu(a, b, op);
    chk("model_z", 64'(e.z), 64'(ez));
    chk("model_flags", 64'({e.ex, e.ovf}), 64'({eex, eovf}));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int   n;
    logic acc;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    do begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int nacc0;
    int budget;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_z", 64'(bus.rsp_z), 64'd0);
    chk("rst_flags", 64'({bus.rsp_ex, bus.rsp_ovf}), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic ops, back to back.
    pin(5, 3, 3'b000, 32'd1, 1'b0, 1'b0);
    pin(5, 3, 3'b101, 32'd7, 1'b0, 1'b0);
    pin(5, 3, 3'b010, 32'd8, 1'b0, 1'b0);
    pin(5, 3, 3'b110, 32'd2, 1'b0, 1'b0);
    pin(5, 3, 3'b111, 32'd0, 1'b1, 1'b0);
    pin(5, 3, 3'b011, 32'd0, 1'b1, 1'b0);
    issue(5, 3, 3'b000);
    issue(5, 3, 3'b101);
    issue(5, 3, 3'b010);
    issue(5, 3, 3'b110);
    issue(5, 3, 3'b111);
    issue(5, 3, 3'b011);
    step(4);

    // Flags and wrap-around.
    pin(32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b0, 1'b1);
    pin(32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1);
    pin(32'h1234, 32'h1234, 3'b110, 32'd0, 1'b1, 1'b0);
    pin(32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 32'd1, 3'b010);
    issue(32'h8000_0000, 32'd1, 3'b110);
    issue(32'h1234, 32'h1234, 3'b110);
    issue(32'hFFFF_FFFF, 32'd1, 3'b111);
    step(4);
    chk("count_after_flags", 64'(op_count), 64'd10);

    // Backpressure: three requests while the consumer stalls for four cycles.
    bus.rsp_ready = 1'b0;
    fork
      begin
        issue(32'd10, 32'd20, 3'b010);
        issue(32'd7, 32'd2, 3'b110);
        issue(32'hF0, 32'h0F, 3'b001);
      end
      begin
        step(3);
        @(negedge clk);
        chk("bp_first_held", 64'(bus.rsp_z), 64'd30);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    step(4);
    chk("bp_count", 64'(op_count), 64'd13);

    // Both stages full, then drain one, advance one and capture one in a single cycle.
    bus.rsp_ready = 1'b0;
    issue(32'd100, 32'd1, 3'b110);
    issue(32'd3, 32'd4, 3'b111);
    bus.rsp_ready = 1'b1;
    issue(32'hFF00, 32'h0FF0, 3'b100);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("simul_full", 64'(bus.req_ready), 64'd0);
    chk("simul_s2", 64'(bus.rsp_z), 64'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    step(4);
    chk("simul_count", 64'(op_count), 64'd16);

    // Reset with two ops in flight.
    bus.rsp_ready = 1'b0;
    issue(32'd1, 32'd2, 3'b010);
    issue(32'd9, 32'd4, 3'b110);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(op_count), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    step(4);

    // Random traffic until 1000 more requests are accepted.
    nacc0 = naccept;
    budget = 0;
    while (naccept - nacc0 < 1000 && budget < 6000) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.req_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: bus.req_a = 32'h7FFF_FFFF;
        1: bus.req_a = 32'h8000_0000;
        default: bus.req_a = $urandom;
      endcase
      bus.req_b = ($urandom_range(0, 3) == 0) ? bus.req_a : $urandom;
      step(1);
      budget++;
    end
    if (naccept - nacc0 < 1000) chk("random_budget", 64'(naccept - nacc0), 64'd1000);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step(5);
    chk("final_count", 64'(op_count), 64'(mcnt));
    chk("final_drained", 64'(bus.rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential, handshaked execution wrapper that serves as the responder side of ALU operand/opcode requests in the RISC-V datapath.
- Accepts {a, b, op} on a valid/ready request channel and computes the same function set as yAlu: AND, OR, ADD, SUB, SLT.
- Returns {z, ex, ovf} on a valid/ready response channel through a 2-stage pipeline with full backpressure.
- Also keeps a completed-operation counter for bench and debug visibility.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_a  input  WIDTH  operand a (signed).
- req_b  input  WIDTH  operand b (signed).
- req_op  input  3  ALU opcode.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_z  output  WIDTH  result.
- rsp_ex  output  1  zero flag: 1 iff rsp_z == 0.
- rsp_ovf  output  1  signed overflow, ADD/SUB only; 0 for all other ops.
- op_count  output  CNT_W  number of responses accepted since reset.

Behaviour:
- Opcode map:
  - op[1:0]=00: AND, for op 000 and 100.
  - op[1:0]=01: OR, for op 001 and 101.
  - 010: ADD.
  - 110: SUB (a-b).
  - 111: SLT, z = {0…0, signed(a)<signed(b)}.
  - 011: z=0.
- Arithmetic is modulo 2^WIDTH.
- ovf:
  - ADD: sign(a)==sign(b) && sign(z)!=sign(a).
  - SUB: sign(a)!=sign(b) && sign(z)!=sign(a).
- Stage S1 (operand register):
  - Captures a, b, op on req_valid && req_ready.
  - s1_valid is set on capture and cleared when S1 advances without a new capture.
- Stage S2 (result register):
  - Computes from S1 and registers z/ex/ovf when S1 advances.
  - rsp_valid = s2_valid.
  - rsp_* are driven only from S2 registers; no combinational path from req_* to rsp_*.
- Advance/ready rules:
  - s2_free = !s2_valid || rsp_ready.
  - S1 advances when s1_valid && s2_free.
  - req_ready = !s1_valid || s2_free. This is combinational from rsp_ready only, never from req_valid.
- Latency and throughput:
  - A request accepted in cycle N appears with rsp_valid=1 in cycle N+2 when rsp_ready stays high.
  - Sustained throughput is 1 op/cycle.
- Backpressure:
  - While rsp_valid && !rsp_ready, rsp_z/rsp_ex/rsp_ovf hold stable.
  - A request already in S1 holds, and req_ready=0.
  - Maximum occupancy is 2 requests; no request is dropped or duplicated; order is preserved.
- Simultaneous events:
  - A response handshake plus S1 advance plus a new capture can all happen in the same cycle.
  - All three take effect; occupancy stays unchanged.
- op_count:
  - Increments by 1 on each rsp_valid && rsp_ready.
  - Wraps from 2^CNT_W-1 to 0.
- Reset (synchronous):
  - s1_valid=0, s2_valid=0, rsp_valid=0.
  - rsp_z=0, rsp_ex=0, rsp_ovf=0, op_count=0.
  - req_ready reads 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight ops without producing a response.
  - While reset=1, req_ready=0.
- Invalid inputs: X/Z on req_* while req_valid=0 must not propagate into S1 or any output.

Test Plan:
- Basic ops, rsp_ready=1, one request per cycle:
  - a=5, b=3: op 000 -> z=1; op 101 -> z=7; op 010 -> z=8; op 110 -> z=2; op 111 -> z=0; op 011 -> z=0, ex=1.
  - Each response arrives exactly 2 cycles after its request is accepted.
- Flags and wrap-around:
  - ADD a=0x7FFFFFFF, b=1 -> z=0x80000000, ovf=1.
  - SUB a=0x80000000, b=1 -> z=0x7FFFFFFF, ovf=1.
  - SUB a=b=0x1234 -> z=0, ex=1, ovf=0.
  - SLT a=-1, b=1 -> z=1.
- Backpressure:
  - Issue 3 back-to-back requests while holding rsp_ready=0 for 4 cycles.
  - req_ready drops to 0 after 2 acceptances; rsp_z holds the first result stable.
  - After release, the 3 results emerge in order with no gaps; op_count=3.
- Simultaneous events:
  - With both stages full, assert rsp_ready=1 and req_valid=1 in the same cycle.
  - The response handshake, S1 advance and new capture all occur in that cycle; occupancy stays at 2.
- Reset mid-flight:
  - Assert reset for 1 cycle with 2 ops in flight.
  - Next cycle: rsp_valid=0, op_count=0, req_ready=1; no stale result ever appears.
- Randomized scoreboard:
  - 1000 random {a, b, op} with random req_valid/rsp_ready, compared against a reference model.
  - Zero mismatches; final op_count equals the number of accepted responses mod 2^CNT_W.
